// File: rtl/dmem_responder_if.sv
// Request/response channel between the datapath's data-memory port and the
// sequential memory responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one load/store, waits WAIT cycles,
// performs the access and holds the response until the requester takes it.
module dmem_responder #(
   parameter int ADDR_BITS = 6,
   parameter int WAIT      = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   localparam int         DEPTH    = 1 << ADDR_BITS;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {IDLE, BUSY, ACCESS, RESP} state_t;

   state_t                 state, state_nx;
   logic [3:0]             cnt;
   logic                   accept;
   logic                   bad;
   logic [ADDR_BITS-1:0]   word;
   logic                   we_p0;
   logic [31:0]            addr_p0;
   logic [31:0]            wdata_p0;
   logic [31:0]            rdata_p1;
   logic                   err_p1;
   logic [31:0]            mem [DEPTH];

   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:ADDR_BITS+2] != '0);
   endfunction

   assign accept = (state == IDLE) && bus.req_valid;
   assign bad    = addr_bad(addr_p0);
   assign word   = addr_p0[ADDR_BITS+1:2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.req_valid) state_nx = (WAIT == 0) ? ACCESS : BUSY;
         BUSY:    if (cnt == 4'd1) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE:    bus.req_ready = 1'b1;
         RESP:    bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                cnt <= 4'd0;
      else if (accept)           cnt <= WAIT_CNT;
      else if (state == BUSY)    cnt <= cnt - 4'd1;
   end

   // request stage: captured once at acceptance, inputs are free afterwards
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p0    <= bus.req_we;
         addr_p0  <= bus.req_addr;
         wdata_p0 <= bus.req_wdata;
      end
   end

   // access stage: a reset before this edge leaves state at IDLE, so no write
   always_ff @(posedge clk) begin
      if (state == ACCESS && we_p0 && !bad) mem[word] <= wdata_p0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_p1 <= 32'd0;
         err_p1   <= 1'b0;
      end else if (state == ACCESS) begin
         rdata_p1 <= (!we_p0 && !bad) ? mem[word] : 32'd0;
         err_p1   <= bad;
      end else if (state == RESP && bus.rsp_ready) begin
         rdata_p1 <= 32'd0;
         err_p1   <= 1'b0;
      end
   end

   assign bus.rsp_rdata = rdata_p1;
   assign bus.rsp_err   = err_p1;
endmodule
